mips_lite_core: RTL and testbench

- Single-cycle MIPS-subset execution block combining the instruction decoder/controller and the datapath: register file, ALU, immediate sign-extender and data memory.
- An external sequencer drives one 32-bit instruction per clock. Results commit on the next rising edge.
- Supports ADD, LW and SW only. No PC and no instruction fetch; the instruction is an input.

---
 rtl/mips_lite_core.sv | 121 ++++++++++++
 tb/tb_mips_lite_core.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mips_lite_core.sv
// Single-cycle ADD/LW/SW execution block: decoder, register file, ALU and data memory.
// Outputs are combinational from Instr and state; writes commit at the next clk edge. There is no backpressure.
module mips_lite_core #(
    parameter int MEM_DEPTH = 256,
    parameter int MEM_AW    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr,
    output logic [31:0] Data_Out,
    output logic        Reg_Dst,
    output logic        Reg_Write,
    output logic        Alu_Src,
    output logic [2:0]  Alu_Control,
    output logic        Mem_Write,
    output logic        Mem_Read,
    output logic        Mem_To_Reg
);

    localparam logic [5:0] OP_ADD = 6'b000001;
    localparam logic [5:0] OP_LW  = 6'b000010;
    localparam logic [5:0] OP_SW  = 6'b000100;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    logic [31:0]       r_regs [32];
    logic [31:0]       r_mem  [MEM_DEPTH];

    logic [5:0]        w_opcode;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [4:0]        w_wr_idx;
    logic [31:0]       w_imm_ext;
    logic [31:0]       w_rs_dat;
    logic [31:0]       w_rt_dat;
    logic [31:0]       w_alu_b;
    logic [31:0]       w_alu_res;
    logic [MEM_AW-1:0] w_mem_idx;
    logic [31:0]       w_mem_rd;

    assign w_opcode  = Instr[31:26];
    assign w_rs      = Instr[25:21];
    assign w_rt      = Instr[20:16];
    assign w_rd      = Instr[15:11];
    assign w_imm_ext = {{16{Instr[15]}}, Instr[15:0]};

    // Unknown opcodes (X/Z included) fall to the default and leave every enable low.
    always_comb begin
        Reg_Dst     = 1'b0;
        Reg_Write   = 1'b0;
        Alu_Src     = 1'b0;
        Alu_Control = 3'b000;
        Mem_Write   = 1'b0;
        Mem_Read    = 1'b0;
        Mem_To_Reg  = 1'b0;
        case (w_opcode)
            OP_ADD: begin
                Reg_Dst     = 1'b1;
                Reg_Write   = 1'b1;
                Alu_Control = ALU_ADD;
            end
            OP_LW: begin
                Reg_Write   = 1'b1;
                Alu_Src     = 1'b1;
                Alu_Control = ALU_ADD;
                Mem_Read    = 1'b1;
                Mem_To_Reg  = 1'b1;
            end
            OP_SW: begin
                Alu_Src     = 1'b1;
                Alu_Control = ALU_ADD;
                Mem_Write   = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_rs_dat = r_regs[w_rs];
    assign w_rt_dat = r_regs[w_rt];
    assign w_alu_b  = Alu_Src ? w_imm_ext : w_rt_dat;

    always_comb begin
        w_alu_res = 32'd0;
        case (Alu_Control)
            ALU_ADD: w_alu_res = w_rs_dat + w_alu_b;
            ALU_SUB: w_alu_res = w_rs_dat - w_alu_b;
            ALU_AND: w_alu_res = w_rs_dat & w_alu_b;
            ALU_OR:  w_alu_res = w_rs_dat | w_alu_b;
            default: w_alu_res = 32'd0;
        endcase
    end

    // Word index drops the upper address bits, so effective addresses wrap.
    assign w_mem_idx = w_alu_res[MEM_AW-1:0];
    assign w_mem_rd  = Mem_Read ? r_mem[w_mem_idx] : 32'd0;
    assign Data_Out  = Mem_To_Reg ? w_mem_rd : w_alu_res;
    assign w_wr_idx  = Reg_Dst ? w_rd : w_rt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= 32'(i);
            end
        end else begin
            if (Reg_Write) begin
                r_regs[w_wr_idx] <= Data_Out;
            end
            if (Mem_Write) begin
                r_mem[w_mem_idx] <= w_rt_dat;
            end
        end
    end

endmodule

// File: tb/tb_mips_lite_core.sv
// Directed bench for mips_lite_core: hand-computed control, Data_Out and committed state.
module tb_mips_lite_core;

    logic        clk;
    logic        rst;
    logic [31:0] Instr;
    logic [31:0] Data_Out;
    logic        Reg_Dst;
    logic        Reg_Write;
    logic        Alu_Src;
    logic [2:0]  Alu_Control;
    logic        Mem_Write;
    logic        Mem_Read;
    logic        Mem_To_Reg;

    int n_checks = 0;
    int n_errors = 0;

    mips_lite_core #(.MEM_DEPTH(256), .MEM_AW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .Instr      (Instr),
        .Data_Out   (Data_Out),
        .Reg_Dst    (Reg_Dst),
        .Reg_Write  (Reg_Write),
        .Alu_Src    (Alu_Src),
        .Alu_Control(Alu_Control),
        .Mem_Write  (Mem_Write),
        .Mem_Read   (Mem_Read),
        .Mem_To_Reg (Mem_To_Reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Control bundle: {Reg_Dst, Reg_Write, Alu_Src, Alu_Control, Mem_Write, Mem_Read, Mem_To_Reg}
    function automatic logic [31:0] ctrl();
        return {23'd0, Reg_Dst, Reg_Write, Alu_Src, Alu_Control, Mem_Write, Mem_Read, Mem_To_Reg};
    endfunction

    localparam logic [31:0] CTRL_ADD = {23'd0, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0};
    localparam logic [31:0] CTRL_LW  = {23'd0, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0, 1'b1, 1'b1};
    localparam logic [31:0] CTRL_SW  = {23'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0};

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] low);
        return {op, rs, rt, low};
    endfunction

    // Present an instruction mid-cycle and let the combinational outputs settle.
    task automatic drive(input logic [31:0] ins);
        @(negedge clk);
        Instr = ins;
        #1;
    endtask

    task automatic commit();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        Instr = 32'd0;
        commit();
        commit();
        check("rst_r1",     dut.r_regs[1],   32'd0);
        check("rst_r31",    dut.r_regs[31],  32'd0);
        check("rst_mem20",  dut.r_mem[20],   32'd20);
        check("rst_mem255", dut.r_mem[255],  32'd255);
        @(negedge clk);
        rst = 1'b0;

        // LW R1 <- mem[0+5]
        drive(enc(6'b000010, 5'd0, 5'd1, 16'd5));
        check("lw1_dout", Data_Out, 32'd5);
        check("lw1_ctrl", ctrl(),   CTRL_LW);
        commit();
        check("lw1_r1", dut.r_regs[1], 32'd5);

        drive(enc(6'b000010, 5'd0, 5'd2, 16'd3));
        check("lw2_dout", Data_Out, 32'd3);
        commit();
        check("lw2_r2", dut.r_regs[2], 32'd3);

        // ADD R3 = R1 + R2
        drive(enc(6'b000001, 5'd1, 5'd2, {5'd3, 11'd0}));
        check("add_dout", Data_Out, 32'd8);
        check("add_ctrl", ctrl(),   CTRL_ADD);
        commit();
        check("add_r3", dut.r_regs[3], 32'd8);
        check("add_r1", dut.r_regs[1], 32'd5);
        check("add_r2", dut.r_regs[2], 32'd3);

        // SW mem[0+20] <- R3
        drive(enc(6'b000100, 5'd0, 5'd3, 16'd20));
        check("sw_dout", Data_Out, 32'd20);
        check("sw_ctrl", ctrl(),   CTRL_SW);
        commit();
        check("sw_mem20", dut.r_mem[20], 32'd8);
        check("sw_r3",    dut.r_regs[3], 32'd8);

        drive(enc(6'b000010, 5'd0, 5'd4, 16'd20));
        check("lw_back_dout", Data_Out, 32'd8);
        commit();
        check("lw_back_r4", dut.r_regs[4], 32'd8);

        // Address 0xFFFFFFFF wraps to index 255
        drive(enc(6'b000010, 5'd0, 5'd5, 16'hFFFF));
        check("lw_wrap_dout", Data_Out, 32'd255);
        commit();
        check("lw_wrap_r5", dut.r_regs[5], 32'd255);

        // rs == rt: address uses the old R1 (5+1)
        drive(enc(6'b000010, 5'd1, 5'd1, 16'd1));
        check("lw_self_dout", Data_Out, 32'd6);
        commit();
        check("lw_self_r1", dut.r_regs[1], 32'd6);

        // R0 is writable
        drive(enc(6'b000010, 5'd0, 5'd0, 16'd7));
        check("lw_r0_dout", Data_Out, 32'd7);
        commit();
        check("lw_r0_r0", dut.r_regs[0], 32'd7);

        // Opcode 0: controls all low, ALU code 000 is AND of R1 (6) and R5 (255)
        drive(enc(6'b000000, 5'd1, 5'd5, {5'd9, 11'd0}));
        check("nop_ctrl", ctrl(),   32'd0);
        check("nop_dout", Data_Out, 32'd6);
        commit();
        check("nop_r9",    dut.r_regs[9], 32'd0);
        check("nop_r5",    dut.r_regs[5], 32'd255);
        check("nop_mem6",  dut.r_mem[6],  32'd6);
        check("nop_mem20", dut.r_mem[20], 32'd8);

        // SW mem[R0(7)+13] <- R5 with reset asserted: reset wins
        drive(enc(6'b000100, 5'd0, 5'd5, 16'd13));
        rst = 1'b1;
        #1;
        check("rstsw_dout", Data_Out, 32'd20);
        check("rstsw_ctrl", ctrl(),   CTRL_SW);
        commit();
        check("rstsw_mem20", dut.r_mem[20],  32'd20);
        check("rstsw_r0",    dut.r_regs[0],  32'd0);
        check("rstsw_r1",    dut.r_regs[1],  32'd0);
        check("rstsw_r5",    dut.r_regs[5],  32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
